// File: rtl/nileswan_unlock_pkg.sv
// nileswan_unlock_pkg: shared state type and default unlock parameters
package nileswan_unlock_pkg;
  typedef enum logic [1:0] {UNL_IDLE, UNL_SHIFT, UNL_DONE} unlock_state_t;
  localparam logic [21:0] UNLOCK_PATTERN_DEF = 22'h028A07;
  localparam int UNLOCK_LEN_DEF = 22;
  localparam logic [11:0] UNLOCK_TRIG_DEF = 12'hA05;
  localparam logic [11:0] UNLOCK_MASK_DEF = 12'hF0F;
endpackage

// File: rtl/unlock_trig_match.sv
// unlock_trig_match: masked, qualified compare of the cartridge address against the trigger
module unlock_trig_match
  import nileswan_unlock_pkg::*;
#(
  parameter logic [11:0] TRIG_ADDR = UNLOCK_TRIG_DEF,
  parameter logic [11:0] TRIG_MASK = UNLOCK_MASK_DEF
) (
  input  logic [7:0] AddrLo,
  input  logic [3:0] AddrHi,
  input  logic       AddrVld,
  output logic       hit
);
  assign hit = AddrVld && ((({AddrHi, AddrLo} ^ TRIG_ADDR) & TRIG_MASK) == 12'h000);
endmodule

// File: rtl/mbc_unlock_seq.sv
// mbc_unlock_seq: serialises the unlock pattern LSB first on Mbc after a trigger, then holds the tail level
module mbc_unlock_seq
  import nileswan_unlock_pkg::*;
#(
  parameter int                     PATTERN_LEN = UNLOCK_LEN_DEF,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = PATTERN_LEN'(UNLOCK_PATTERN_DEF),
  parameter logic [11:0]            TRIG_ADDR   = UNLOCK_TRIG_DEF,
  parameter logic [11:0]            TRIG_MASK   = UNLOCK_MASK_DEF,
  parameter logic                   TAIL_LEVEL  = 1'b1,
  parameter logic                   ONESHOT     = 1'b0
) (
  input  logic       SClk,
  input  logic       nReset,
  input  logic [7:0] AddrLo,
  input  logic [3:0] AddrHi,
  input  logic       AddrVld,
  input  logic       Rearm,
  output logic       Mbc,
  output logic       Busy,
  output logic       Done
);
  localparam int IDX_W = $clog2(PATTERN_LEN);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(PATTERN_LEN - 1);
  unlock_state_t state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic mbc_nx, hit, rearm;
  unlock_trig_match #(.TRIG_ADDR(TRIG_ADDR), .TRIG_MASK(TRIG_MASK)) u_trig (
    .AddrLo (AddrLo),
    .AddrHi (AddrHi),
    .AddrVld(AddrVld),
    .hit    (hit)
  );
  assign rearm = Rearm && !ONESHOT;
  // Rearm wins over everything, including a hit on the same edge while idle
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    mbc_nx   = Mbc;
    if (rearm) begin
      state_nx = UNL_IDLE;
      idx_nx   = '0;
      mbc_nx   = PATTERN[0];
    end else begin
      case (state)
        UNL_IDLE: if (hit) begin
          state_nx = UNL_SHIFT;
          idx_nx   = '0;
          mbc_nx   = PATTERN[0];
        end
        UNL_SHIFT: if (idx == LAST) begin
          state_nx = UNL_DONE;
          mbc_nx   = TAIL_LEVEL;
        end else begin
          idx_nx = idx + 1'b1;
          mbc_nx = PATTERN[idx_nx];
        end
        UNL_DONE: state_nx = UNL_DONE;
        default: begin
          state_nx = UNL_IDLE;
          idx_nx   = '0;
          mbc_nx   = PATTERN[0];
        end
      endcase
    end
  end
  always_ff @(posedge SClk or negedge nReset) begin
    if (!nReset) begin
      state <= UNL_IDLE;
      idx   <= '0;
      Mbc   <= PATTERN[0];
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      Mbc   <= mbc_nx;
    end
  end
  assign Busy = (state == UNL_SHIFT);
  assign Done = (state == UNL_DONE);
  a_excl: assert property (@(posedge SClk) disable iff (!nReset) !(Busy && Done));
  a_busy: assert property (@(posedge SClk) disable iff (!nReset) Busy |-> state == UNL_SHIFT);
endmodule

// File: tb/tb_mbc_unlock_seq.sv
// tb_mbc_unlock_seq: scoreboard bench over default, one-shot and 8-bit-pattern instances
module tb_mbc_unlock_seq;
  typedef struct {int inst; logic m; logic b; logic d; string nm;} exp_t;
  localparam logic [0:21] E22 = 22'b1110000001010001010000;
  localparam logic [0:7]  E8  = 8'b10100101;
  logic SClk;
  logic [11:0] addr [3];
  logic vld [3], rearm [3], rstn [3];
  logic mbc [3], busy [3], done [3];
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  initial SClk = 1'b0;
  always #5 SClk = ~SClk;
  mbc_unlock_seq dut (
    .SClk(SClk), .nReset(rstn[0]), .AddrLo(addr[0][7:0]), .AddrHi(addr[0][11:8]),
    .AddrVld(vld[0]), .Rearm(rearm[0]), .Mbc(mbc[0]), .Busy(busy[0]), .Done(done[0])
  );
  mbc_unlock_seq #(.ONESHOT(1'b1)) dut_os (
    .SClk(SClk), .nReset(rstn[1]), .AddrLo(addr[1][7:0]), .AddrHi(addr[1][11:8]),
    .AddrVld(vld[1]), .Rearm(rearm[1]), .Mbc(mbc[1]), .Busy(busy[1]), .Done(done[1])
  );
  mbc_unlock_seq #(.PATTERN_LEN(8), .PATTERN(8'hA5)) dut8 (
    .SClk(SClk), .nReset(rstn[2]), .AddrLo(addr[2][7:0]), .AddrHi(addr[2][11:8]),
    .AddrVld(vld[2]), .Rearm(rearm[2]), .Mbc(mbc[2]), .Busy(busy[2]), .Done(done[2])
  );
  task automatic cmp(input int i, input logic m, input logic b, input logic d, input string nm);
    n_chk++;
    if ({mbc[i], busy[i], done[i]} !== {m, b, d}) begin
      n_fail++;
      $display("FAIL %s inst=%0d mbc/busy/done got %b%b%b want %b%b%b", nm, i,
               mbc[i], busy[i], done[i], m, b, d);
    end
  endtask
  always @(negedge SClk)
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp(e.inst, e.m, e.b, e.d, e.nm);
    end
  task automatic drive(input int i, input logic [11:0] a, input logic v, input logic r);
    addr[i] = a;
    vld[i] = v;
    rearm[i] = r;
  endtask
  task automatic step(input int i, input logic m, input logic b, input logic d, input string nm);
    @(posedge SClk);
    #1;
    sb.push_back('{i, m, b, d, nm});
  endtask
  task automatic exp_bit(input int len, input int j, output logic m);
    m = (len == 22) ? E22[j] : E8[j];
  endtask
  task automatic run_seq(input int i, input int len, input string nm);
    logic m;
    for (int j = 0; j < len; j++) begin
      exp_bit(len, j, m);
      step(i, m, 1'b1, 1'b0, nm);
    end
    step(i, 1'b1, 1'b0, 1'b1, {nm, "_tail"});
  endtask
  task automatic rearm_test(input int i, input int len, input string nm);
    logic m;
    drive(i, 12'hA05, 1'b1, 1'b0);
    for (int j = 0; j < 5; j++) begin
      exp_bit(len, j, m);
      step(i, m, 1'b1, 1'b0, {nm, "_pre"});
      drive(i, 12'hA05, 1'b0, 1'b0);
    end
    drive(i, 12'hA05, 1'b1, 1'b1);
    step(i, 1'b1, 1'b0, 1'b0, {nm, "_rearm"});
    drive(i, 12'h000, 1'b0, 1'b0);
    step(i, 1'b1, 1'b0, 1'b0, {nm, "_idle"});
    drive(i, 12'hAF5, 1'b1, 1'b0);
    run_seq(i, len, {nm, "_replay"});
    drive(i, 12'h000, 1'b0, 1'b1);
    step(i, 1'b1, 1'b0, 1'b0, {nm, "_back"});
  endtask
  initial begin
    #100000;
    $display("FAIL timeout bench did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 3; i++) begin
      drive(i, 12'h000, 1'b0, 1'b0);
      rstn[i] = 1'b0;
    end
    #12;
    for (int i = 0; i < 3; i++) cmp(i, 1'b1, 1'b0, 1'b0, "reset");
    for (int i = 0; i < 3; i++) rstn[i] = 1'b1;
    drive(0, 12'h000, 1'b1, 1'b0);
    for (int j = 0; j < 10; j++) step(0, 1'b1, 1'b0, 1'b0, "idle_000");
    drive(0, 12'hA35, 1'b1, 1'b0);
    run_seq(0, 22, "pat22");
    for (int j = 0; j < 3; j++) step(0, 1'b1, 1'b0, 1'b1, "done_hold_hit");
    drive(0, 12'h000, 1'b0, 1'b1);
    step(0, 1'b1, 1'b0, 1'b0, "rearm_from_done");
    drive(0, 12'hA05, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) step(0, 1'b1, 1'b0, 1'b0, "no_vld");
    drive(0, 12'hA06, 1'b1, 1'b0);
    for (int j = 0; j < 3; j++) step(0, 1'b1, 1'b0, 1'b0, "no_match");
    rearm_test(0, 22, "rearm22");
    drive(0, 12'hA05, 1'b1, 1'b1);
    for (int j = 0; j < 2; j++) step(0, 1'b1, 1'b0, 1'b0, "rearm_hit_idle");
    drive(0, 12'h000, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0, "idle_after");
    drive(1, 12'hA35, 1'b1, 1'b0);
    run_seq(1, 22, "os");
    drive(1, 12'hA05, 1'b1, 1'b1);
    for (int j = 0; j < 2; j++) step(1, 1'b1, 1'b0, 1'b1, "os_rearm_ignored");
    drive(1, 12'h000, 1'b0, 1'b0);
    @(negedge SClk);
    #1 rstn[1] = 1'b0;
    #1 cmp(1, 1'b1, 1'b0, 1'b0, "os_async_rst");
    #1 rstn[1] = 1'b1;
    step(1, 1'b1, 1'b0, 1'b0, "os_idle");
    drive(1, 12'hA05, 1'b1, 1'b0);
    run_seq(1, 22, "os_retrig");
    drive(0, 12'hA05, 1'b1, 1'b0);
    for (int j = 0; j < 8; j++) begin
      step(0, E22[j], 1'b1, 1'b0, "mid_shift");
      drive(0, 12'h000, 1'b0, 1'b0);
    end
    @(negedge SClk);
    #1 rstn[0] = 1'b0;
    #1 cmp(0, 1'b1, 1'b0, 1'b0, "async_rst_mid");
    step(0, 1'b1, 1'b0, 1'b0, "held_rst");
    #2 rstn[0] = 1'b1;
    step(0, 1'b1, 1'b0, 1'b0, "post_rst_idle");
    drive(0, 12'hA35, 1'b1, 1'b0);
    run_seq(0, 22, "post_rst_pat");
    drive(2, 12'hA35, 1'b1, 1'b0);
    run_seq(2, 8, "pat8");
    drive(2, 12'h000, 1'b0, 1'b1);
    step(2, 1'b1, 1'b0, 1'b0, "pat8_rearm");
    rearm_test(2, 8, "rearm8");
    @(negedge SClk);
    #1;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
